// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads a synchronous RAM port, and feeds
// decode through a small skid buffer with valid/ready handshake and redirect flush.
module instr_fetch #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0] i_read_data,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  fetch_valid,
    input  logic                  fetch_ready,
    output logic [31:0]           fetch_pc,
    output logic [DATA_WIDTH-1:0] fetch_instr
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [31:0]           pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    logic [31:0]      pc_q, pc_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           buf_q [BUF_DEPTH];

    logic             pop;
    logic             push;
    logic             issue;
    logic [OCC_W-1:0] occupancy;
    logic [31:0]      redirect_target;
    entry_t           push_entry;
    entry_t           head_entry;

    assign i_address   = pc_q[ADDR_WIDTH+1:2];
    assign fetch_valid = (count_q != '0);
    assign head_entry  = buf_q[rd_ptr_q];
    // Masking keeps never-written storage from leaking onto the outputs.
    assign fetch_pc    = fetch_valid ? head_entry.pc    : '0;
    assign fetch_instr = fetch_valid ? head_entry.instr : '0;

    // Handshake, issue decision and next-state computation.
    always_comb begin
        pop             = fetch_valid && fetch_ready && !redirect_valid;
        push            = inflight_q && !redirect_valid;
        occupancy       = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
        issue           = !redirect_valid && (occupancy < OCC_W'(BUF_DEPTH));
        redirect_target = redirect_pc & ~32'h0000_0003;
        push_entry.pc    = inflight_pc_q;
        push_entry.instr = i_read_data;

        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (redirect_valid) begin
            pc_d     = redirect_target;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                inflight_pc_d = pc_q;
                pc_d          = pc_q + 32'd4;
            end
            if (push) begin
                wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(1));
            end
            if (pop) begin
                rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
            end
            if (push && !pop) begin
                count_d = CNT_W'(count_q + CNT_W'(1));
            end else if (pop && !push) begin
                count_d = CNT_W'(count_q - CNT_W'(1));
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Entry storage carries no reset; validity lives entirely in count_q.
    always_ff @(posedge clock) begin
        if (push) begin
            buf_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule
